alu_op_sequencer: RTL and testbench

Multi-cycle sequencer that implements 64-bit unsigned MUL (low 64 bits) and UDIV (quotient and remainder) for the LEGv8 datapath. It is the driving end of the ALU interface. It issues A, B, FS and C0 to an external ALU_LEGv8 instance each cycle, and captures F and status back. Shifts and bookkeeping are local; every add and subtract goes through the ALU.

---
 rtl/alu_op_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle 64-bit unsigned MUL (low half) and restoring UDIV that drives an external LEGv8 ALU.
// Build option: define MUL_EARLY_EXIT_EN to end MUL once no multiplier bits remain.
module alu_op_sequencer #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_lo,
   output logic [WIDTH-1:0] out_hi,
   output logic [3:0]       out_status,
   output logic             out_dbz,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [4:0]       alu_FS,
   output logic             alu_C0,
   input  logic [WIDTH-1:0] alu_F,
   input  logic [3:0]       alu_status
);

   localparam logic [4:0]       FS_ADD   = 5'b01000;
   localparam logic [4:0]       FS_SUB   = 5'b01001;
   localparam logic [4:0]       FS_ZERO  = 5'b11000;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           state_r;
   logic [WIDTH-1:0] acc_r;    // P for MUL, R for UDIV
   logic [WIDTH-1:0] opnd_r;   // M for MUL, D for UDIV
   logic [WIDTH-1:0] quo_r;    // Q for both
   logic [CNT_W-1:0] cnt_r;

   logic [WIDTH-1:0] rs_s;
   logic [WIDTH-1:0] mul_p_s;
   logic [WIDTH-1:0] div_r_s;
   logic [WIDTH-1:0] div_q_s;
   logic [WIDTH-1:0] q_shift_s;
   logic             take_s;
   logic             mul_last_s;
   logic             mul_skip_s;
   logic             unused_status_s;

   function automatic logic [3:0] lo_status(input logic [WIDTH-1:0] v);
      return {1'b0, 1'b0, v[WIDTH-1], (v == ZERO_W)};
   endfunction

   assign unused_status_s = ^{alu_status[3], alu_status[1:0]};

`ifdef MUL_EARLY_EXIT_EN
   assign mul_skip_s = (in_b == ZERO_W);
   assign mul_last_s = (cnt_r == CNT_LAST) || (q_shift_s == ZERO_W);
`else
   assign mul_skip_s = 1'b0;
   assign mul_last_s = (cnt_r == CNT_LAST);
`endif

   // ALU drive per state and next-value datapath for one iteration
   always_comb begin
      rs_s      = {acc_r[WIDTH-2:0], quo_r[WIDTH-1]};
      take_s    = acc_r[WIDTH-1] | alu_status[2];
      mul_p_s   = quo_r[0] ? alu_F : acc_r;
      div_r_s   = take_s ? alu_F : rs_s;
      div_q_s   = {quo_r[WIDTH-2:0], take_s};
      q_shift_s = quo_r >> 1;
      case (state_r)
         S_MUL: begin
            alu_A  = acc_r;
            alu_B  = opnd_r;
            alu_FS = FS_ADD;
            alu_C0 = 1'b0;
         end
         S_DIV: begin
            alu_A  = rs_s;
            alu_B  = opnd_r;
            alu_FS = FS_SUB;
            alu_C0 = 1'b1;
         end
         default: begin
            alu_A  = ZERO_W;
            alu_B  = ZERO_W;
            alu_FS = FS_ZERO;
            alu_C0 = 1'b0;
         end
      endcase
   end

   // Sequencer state, iteration registers and registered result outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= S_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_lo     <= ZERO_W;
         out_hi     <= ZERO_W;
         out_status <= 4'b0000;
         out_dbz    <= 1'b0;
         acc_r      <= ZERO_W;
         opnd_r     <= ZERO_W;
         quo_r      <= ZERO_W;
         cnt_r      <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  out_dbz  <= 1'b0;
                  if (!in_op && mul_skip_s) begin
                     state_r    <= S_DONE;
                     out_valid  <= 1'b1;
                     out_lo     <= ZERO_W;
                     out_hi     <= ZERO_W;
                     out_status <= lo_status(ZERO_W);
                  end else if (!in_op) begin
                     state_r <= S_MUL;
                     acc_r   <= ZERO_W;
                     opnd_r  <= in_a;
                     quo_r   <= in_b;
                     cnt_r   <= CNT_INIT;
                  end else if (in_b == ZERO_W) begin
                     state_r    <= S_DONE;
                     out_valid  <= 1'b1;
                     out_lo     <= ZERO_W;
                     out_hi     <= in_a;
                     out_status <= lo_status(ZERO_W);
                     out_dbz    <= 1'b1;
                  end else begin
                     state_r <= S_DIV;
                     acc_r   <= ZERO_W;
                     opnd_r  <= in_b;
                     quo_r   <= in_a;
                     cnt_r   <= CNT_INIT;
                  end
               end
            end
            S_MUL: begin
               acc_r  <= mul_p_s;
               opnd_r <= opnd_r << 1;
               quo_r  <= q_shift_s;
               cnt_r  <= cnt_r - CNT_LAST;
               if (mul_last_s) begin
                  state_r    <= S_DONE;
                  out_valid  <= 1'b1;
                  out_lo     <= mul_p_s;
                  out_hi     <= ZERO_W;
                  out_status <= lo_status(mul_p_s);
               end
            end
            S_DIV: begin
               acc_r <= div_r_s;
               quo_r <= div_q_s;
               cnt_r <= cnt_r - CNT_LAST;
               if (cnt_r == CNT_LAST) begin
                  state_r    <= S_DONE;
                  out_valid  <= 1'b1;
                  out_lo     <= div_q_s;
                  out_hi     <= div_r_s;
                  out_status <= lo_status(div_q_s);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_r   <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural LEGv8 ALU stand-in plus an arithmetic reference model.
module tb_alu_op_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_op = 1'b0;
   logic [63:0] in_a = 64'd0;
   logic [63:0] in_b = 64'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_lo, out_hi;
   logic [3:0]  out_status;
   logic        out_dbz;
   logic [63:0] alu_A, alu_B, alu_F;
   logic [4:0]  alu_FS;
   logic        alu_C0;
   logic [3:0]  alu_status;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   alu_op_sequencer dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_lo(out_lo), .out_hi(out_hi),
      .out_status(out_status), .out_dbz(out_dbz),
      .alu_A(alu_A), .alu_B(alu_B), .alu_FS(alu_FS), .alu_C0(alu_C0),
      .alu_F(alu_F), .alu_status(alu_status)
   );

   // Behavioural LEGv8 ALU: FS[4:2] selects the function, FS[1]/FS[0] invert A/B
   logic [63:0] alu_aa, alu_bb;
   logic [64:0] alu_sum;
   logic        alu_v, alu_c;
   always_comb begin
      alu_aa  = alu_FS[1] ? ~alu_A : alu_A;
      alu_bb  = alu_FS[0] ? ~alu_B : alu_B;
      alu_sum = {1'b0, alu_aa} + {1'b0, alu_bb} + {64'd0, alu_C0};
      alu_v   = 1'b0;
      alu_c   = 1'b0;
      case (alu_FS[4:2])
         3'b000: alu_F = alu_aa & alu_bb;
         3'b001: alu_F = alu_aa | alu_bb;
         3'b010: begin
            alu_F = alu_sum[63:0];
            alu_c = alu_sum[64];
            alu_v = (alu_aa[63] == alu_bb[63]) && (alu_sum[63] != alu_aa[63]);
         end
         3'b011: alu_F = alu_aa ^ alu_bb;
         default: alu_F = 64'd0;
      endcase
      alu_status = {alu_v, alu_c, alu_F[63], (alu_F == 64'd0)};
   end

   function automatic logic [3:0] model_status(input logic [63:0] v);
      return {2'b00, v[63], (v == 64'd0)};
   endfunction

   function automatic int model_latency(input logic op, input logic [63:0] b);
      int top;
      if (op && b == 64'd0) return 1;
`ifdef MUL_EARLY_EXIT_EN
      if (!op) begin
         if (b == 64'd0) return 1;
         top = 0;
         for (int i = 0; i < 64; i++) if (b[i]) top = i;
         return top + 2;
      end
`endif
      top = 0;
      return 65 + top;
   endfunction

   // Drives one operation, waits for its result, optionally holds it, then handshakes it away
   task automatic run_op(input logic op, input logic [63:0] a, input logic [63:0] b,
                         input bit busy_valid, input int hold,
                         output logic [63:0] lo, output logic [63:0] hi, output logic [3:0] st,
                         output logic dbz, output int lat, output int drive_bad, output int hs_bad);
      lo = 64'd0; hi = 64'd0; st = 4'd0; dbz = 1'b0; lat = 0; drive_bad = 0; hs_bad = 0;
      @(negedge clock);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      @(posedge clock);
      for (int k = 1; k <= 300; k++) begin
         @(negedge clock);
         if (busy_valid) begin
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            in_op = ~op;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid === 1'b1) begin
            lat = k;
            break;
         end
         if (in_ready !== 1'b0) hs_bad++;
         if (!op && (alu_FS !== 5'b01000 || alu_C0 !== 1'b0)) drive_bad++;
         if (op && (alu_FS !== 5'b01001 || alu_C0 !== 1'b1)) drive_bad++;
      end
      if (lat != 0) begin
         lo = out_lo; hi = out_hi; st = out_status; dbz = out_dbz;
         for (int h = 0; h < hold; h++) begin
            if (alu_FS !== 5'b11000 || alu_A !== 64'd0 || alu_B !== 64'd0 || alu_C0 !== 1'b0) drive_bad++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_lo !== lo || out_hi !== hi ||
                out_status !== st || out_dbz !== dbz) hs_bad++;
            @(negedge clock);
         end
         out_ready = 1'b1;
         @(posedge clock);
         @(negedge clock);
         out_ready = 1'b0;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) hs_bad++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_lo !== 64'd0 || out_hi !== 64'd0 ||
          out_status !== 4'd0 || out_dbz !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b vld=%b lo=%h hi=%h st=%b dbz=%b, expected rdy=1 vld=0 rest 0",
                  in_ready, out_valid, out_lo, out_hi, out_status, out_dbz);
      end
      checks++;
      if (alu_FS !== 5'b11000 || alu_A !== 64'd0 || alu_C0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_alu_drive: got FS=%b A=%h C0=%b, expected FS=11000 A=0 C0=0", alu_FS, alu_A, alu_C0);
      end
   endtask

   task automatic test_directed();
      logic        t_op [6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [63:0] t_a  [6]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'h1_2345_6789, 64'd5};
      logic [63:0] t_b  [6]  = '{64'd6, 64'd2, 64'd7, 64'h8000_0000_0000_0001, 64'd0, 64'd9};
      logic [63:0] lo, hi, e_lo, e_hi;
      logic [3:0]  st;
      logic        dbz;
      int          lat, dbad, hbad;
      for (int i = 0; i < 6; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], 1'b0, 2, lo, hi, st, dbz, lat, dbad, hbad);
         e_lo = t_op[i] ? t_a[i] / t_b[i] : t_a[i] * t_b[i];
         e_hi = t_op[i] ? t_a[i] % t_b[i] : 64'd0;
         checks++;
         if (lo !== e_lo || hi !== e_hi) begin
            errors++;
            $display("FAIL directed_%0d_result: got lo=%h hi=%h, expected lo=%h hi=%h", i, lo, hi, e_lo, e_hi);
         end
         checks++;
         if (st !== model_status(e_lo) || dbz !== 1'b0) begin
            errors++;
            $display("FAIL directed_%0d_status: got st=%b dbz=%b, expected st=%b dbz=0", i, st, dbz, model_status(e_lo));
         end
         checks++;
         if (lat != model_latency(t_op[i], t_b[i])) begin
            errors++;
            $display("FAIL directed_%0d_latency: got %0d, expected %0d", i, lat, model_latency(t_op[i], t_b[i]));
         end
         checks++;
         if (dbad != 0 || hbad != 0) begin
            errors++;
            $display("FAIL directed_%0d_protocol: got %0d bad ALU drives and %0d bad handshake samples, expected 0 and 0",
                     i, dbad, hbad);
         end
      end
   endtask

   task automatic test_div_by_zero();
      logic [63:0] lo, hi;
      logic [3:0]  st;
      logic        dbz;
      int          lat, dbad, hbad;
      run_op(1'b1, 64'd55, 64'd0, 1'b0, 5, lo, hi, st, dbz, lat, dbad, hbad);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL dbz_latency: got %0d, expected 1", lat);
      end
      checks++;
      if (lo !== 64'd0 || hi !== 64'd55 || dbz !== 1'b1 || st !== 4'b0001) begin
         errors++;
         $display("FAIL dbz_result: got lo=%h hi=%h dbz=%b st=%b, expected lo=0 hi=37 dbz=1 st=0001", lo, hi, dbz, st);
      end
      checks++;
      if (dbad != 0 || hbad != 0) begin
         errors++;
         $display("FAIL dbz_hold: got %0d bad ALU drives and %0d unstable samples, expected 0 and 0", dbad, hbad);
      end
      // dbz must clear on the next acceptance
      run_op(1'b1, 64'd20, 64'd3, 1'b0, 0, lo, hi, st, dbz, lat, dbad, hbad);
      checks++;
      if (dbz !== 1'b0 || lo !== 64'd6 || hi !== 64'd2) begin
         errors++;
         $display("FAIL dbz_clear: got dbz=%b lo=%h hi=%h, expected dbz=0 lo=6 hi=2", dbz, lo, hi);
      end
   endtask

   task automatic test_reset_mid_div();
      logic [63:0] lo, hi;
      logic [3:0]  st;
      logic        dbz;
      int          lat, dbad, hbad, stray;
      @(negedge clock);
      in_valid = 1'b1; in_op = 1'b1; in_a = 64'hDEAD_BEEF_0000_1234; in_b = 64'd3;
      @(posedge clock);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clock);
         in_valid = 1'b0;
      end
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_lo !== 64'd0 || out_hi !== 64'd0 ||
          out_status !== 4'd0 || out_dbz !== 1'b0) begin
         errors++;
         $display("FAIL mid_div_reset: got rdy=%b vld=%b lo=%h hi=%h st=%b, expected rdy=1 vld=0 rest 0",
                  in_ready, out_valid, out_lo, out_hi, out_status);
      end
      stray = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clock);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL mid_div_abandon: got %0d cycles with a stray result, expected 0", stray);
      end
      run_op(1'b1, 64'd1000, 64'd33, 1'b0, 1, lo, hi, st, dbz, lat, dbad, hbad);
      checks++;
      if (lo !== 64'd30 || hi !== 64'd10 || lat != 65 || dbad != 0 || hbad != 0) begin
         errors++;
         $display("FAIL mid_div_recover: got lo=%h hi=%h lat=%0d, expected lo=1e hi=a lat=65", lo, hi, lat);
      end
   endtask

   task automatic test_random();
      logic        op;
      logic [63:0] a, b, lo, hi, e_lo, e_hi;
      logic [3:0]  st;
      logic        dbz, e_dbz;
      int          lat, dbad, hbad, sel;
      for (int i = 0; i < 30; i++) begin
         op  = 1'($urandom_range(0, 1));
         a   = {$urandom, $urandom};
         sel = $urandom_range(0, 7);
         case (sel)
            0:       b = 64'd0;
            1, 2:    b = 64'($urandom_range(1, 255));
            3:       b = 64'd1 << $urandom_range(0, 63);
            4:       b = {1'b1, 31'($urandom), 32'($urandom)};
            default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
         endcase
         if (sel == 6) a = 64'($urandom_range(0, 100));
         e_dbz = op && (b == 64'd0);
         e_lo  = !op ? a * b : (e_dbz ? 64'd0 : a / b);
         e_hi  = !op ? 64'd0 : (e_dbz ? a : a % b);
         run_op(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), lo, hi, st, dbz, lat, dbad, hbad);
         checks++;
         if (lo !== e_lo || hi !== e_hi || dbz !== e_dbz || st !== model_status(e_lo)) begin
            errors++;
            $display("FAIL random_%0d_result: op=%b a=%h b=%h got lo=%h hi=%h st=%b dbz=%b, expected lo=%h hi=%h st=%b dbz=%b",
                     i, op, a, b, lo, hi, st, dbz, e_lo, e_hi, model_status(e_lo), e_dbz);
         end
         checks++;
         if (lat != model_latency(op, b) || dbad != 0 || hbad != 0) begin
            errors++;
            $display("FAIL random_%0d_timing: got lat=%0d dbad=%0d hbad=%0d, expected lat=%0d dbad=0 hbad=0",
                     i, lat, dbad, hbad, model_latency(op, b));
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_by_zero();
      test_reset_mid_div();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
